// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 phase scheduler.
// Holds the state encoding, the phase codes and the memory port widths.
package rc4_pkg;

    localparam int ADDR_W      = 8;
    localparam int DATA_W      = 8;
    localparam int TIMEOUT_DEF = 8192;
    localparam int CNT_W       = 16;

    localparam logic [1:0] PH_NONE = 2'd0;
    localparam logic [1:0] PH_INIT = 2'd1;
    localparam logic [1:0] PH_KSA  = 2'd2;
    localparam logic [1:0] PH_PRGA = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_KSA,
        ST_PRGA,
        ST_DONE,
        ST_ERR
    } state_t;

    function automatic logic is_phase(input state_t s);
        return (s == ST_INIT) || (s == ST_KSA) || (s == ST_PRGA);
    endfunction

endpackage

// File: rtl/phase_watchdog.sv
// Per-phase cycle counter; flags expiry when a phase has run TIMEOUT cycles.
// Clear has priority so each phase starts counting from zero.
module phase_watchdog
    import rc4_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_expire = i_enable && (r_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/rc4_sched.sv
// RC4 phase sequencer: steps init -> KSA -> PRGA and routes the active
// engine onto the shared S-memory port with no added latency.
module rc4_sched
    import rc4_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              done,
    output logic              err,
    output logic [1:0]        phase,
    output logic              init_start,
    output logic              ksa_start,
    output logic              prga_start,
    input  logic              init_finish,
    input  logic              ksa_finish,
    input  logic              prga_finish,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [ADDR_W-1:0] ksa_addr,
    input  logic [ADDR_W-1:0] prga_addr,
    input  logic [DATA_W-1:0] init_data,
    input  logic [DATA_W-1:0] ksa_data,
    input  logic [DATA_W-1:0] prga_data,
    input  logic              init_wren,
    input  logic              ksa_wren,
    input  logic              prga_wren,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_data,
    output logic              s_wren
);

    state_t r_state;
    state_t w_next;
    logic   w_expire;
    logic   w_clear;
    logic   w_enable;

    assign w_enable = is_phase(r_state);
    // Any state change restarts the count, so every phase entry sees zero.
    assign w_clear  = (w_next != r_state);

    phase_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_clear),
        .i_enable (w_enable),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Abort beats finish, and finish beats a same-cycle expiry.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next = ST_INIT;
            ST_INIT: begin
                if (!start)           w_next = ST_IDLE;
                else if (init_finish) w_next = ST_KSA;
                else if (w_expire)    w_next = ST_ERR;
            end
            ST_KSA: begin
                if (!start)           w_next = ST_IDLE;
                else if (ksa_finish)  w_next = ST_PRGA;
                else if (w_expire)    w_next = ST_ERR;
            end
            ST_PRGA: begin
                if (!start)           w_next = ST_IDLE;
                else if (prga_finish) w_next = ST_DONE;
                else if (w_expire)    w_next = ST_ERR;
            end
            ST_DONE, ST_ERR: if (!start) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        done       = 1'b0;
        err        = 1'b0;
        phase      = PH_NONE;
        init_start = 1'b0;
        ksa_start  = 1'b0;
        prga_start = 1'b0;
        s_addr     = '0;
        s_data     = '0;
        s_wren     = 1'b0;
        case (r_state)
            ST_INIT: begin
                phase      = PH_INIT;
                init_start = 1'b1;
                s_addr     = init_addr;
                s_data     = init_data;
                s_wren     = init_wren;
            end
            ST_KSA: begin
                phase     = PH_KSA;
                ksa_start = 1'b1;
                s_addr    = ksa_addr;
                s_data    = ksa_data;
                s_wren    = ksa_wren;
            end
            ST_PRGA: begin
                phase      = PH_PRGA;
                prga_start = 1'b1;
                s_addr     = prga_addr;
                s_data     = prga_data;
                s_wren     = prga_wren;
            end
            ST_DONE: done = 1'b1;
            ST_ERR:  err  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rc4_sched.sv
// Bench for rc4_sched: mux vector table, hand-written schedule/timeout/reset
// sequences, and a randomized run against an abstract phase model.
module tb_rc4_sched;

    localparam int TO = 1000;

    logic       clk;
    logic       rst;
    logic       start;
    logic       done, err;
    logic [1:0] phase;
    logic       init_start, ksa_start, prga_start;
    logic       init_finish, ksa_finish, prga_finish;
    logic [7:0] init_addr, ksa_addr, prga_addr;
    logic [7:0] init_data, ksa_data, prga_data;
    logic       init_wren, ksa_wren, prga_wren;
    logic [7:0] s_addr, s_data;
    logic       s_wren;

    int n_chk  = 0;
    int n_fail = 0;

    rc4_sched #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .done(done), .err(err), .phase(phase),
        .init_start(init_start), .ksa_start(ksa_start), .prga_start(prga_start),
        .init_finish(init_finish), .ksa_finish(ksa_finish), .prga_finish(prga_finish),
        .init_addr(init_addr), .ksa_addr(ksa_addr), .prga_addr(prga_addr),
        .init_data(init_data), .ksa_data(ksa_data), .prga_data(prga_data),
        .init_wren(init_wren), .ksa_wren(ksa_wren), .prga_wren(prga_wren),
        .s_addr(s_addr), .s_data(s_data), .s_wren(s_wren)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: sim time limit reached, got running required finished");
        $fatal(1, "time limit");
    end

    typedef struct {
        int         ph;
        logic [7:0] ia, id, ka, kd, pa, pd;
        logic       iw, kw, pw;
        logic [7:0] ea, ed;
        logic       ew;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_engines();
        init_finish = 0; ksa_finish = 0; prga_finish = 0;
        init_wren = 0; ksa_wren = 0; prga_wren = 0;
        init_addr = 0; ksa_addr = 0; prga_addr = 0;
        init_data = 0; ksa_data = 0; prga_data = 0;
    endtask

    // Reset, then walk the sequence to ph: 0 idle, 1 init, 2 ksa, 3 prga, 4 done.
    task automatic goto(input int ph);
        start = 0;
        clear_engines();
        rst = 0;
        #2;
        rst = 1;
        if (ph >= 1) begin start = 1; tick(); end
        if (ph >= 2) begin init_finish = 1; tick(); init_finish = 0; end
        if (ph >= 3) begin ksa_finish = 1; tick(); ksa_finish = 0; end
        if (ph >= 4) begin prga_finish = 1; tick(); prga_finish = 0; end
    endtask

    // Abstract model: ms 0 idle, 1..3 engine phases, 4 done, 5 err.
    int ms, mcnt;

    task automatic model_step();
        logic [2:0] fin;
        fin = {prga_finish, ksa_finish, init_finish};
        if (ms == 0) begin
            if (start) begin ms = 1; mcnt = 0; end
        end else if (ms <= 3) begin
            if (!start)              ms = 0;
            else if (fin[ms-1])      begin ms = ms + 1; mcnt = 0; end
            else if (mcnt == TO - 1) ms = 5;
            else                     mcnt++;
        end else if (!start) begin
            ms = 0;
        end
    endtask

    task automatic check_model(input int cyc);
        logic [7:0]  ea, ed;
        logic        ew;
        logic [23:0] act, exp;
        ea = 0; ed = 0; ew = 0;
        if (ms == 1) begin ea = init_addr; ed = init_data; ew = init_wren; end
        if (ms == 2) begin ea = ksa_addr;  ed = ksa_data;  ew = ksa_wren;  end
        if (ms == 3) begin ea = prga_addr; ed = prga_data; ew = prga_wren; end
        exp = {(ms >= 1 && ms <= 3) ? 2'(ms) : 2'd0, ms == 4, ms == 5,
               ms == 1, ms == 2, ms == 3, ea, ed, ew};
        act = {phase, done, err, init_start, ksa_start, prga_start, s_addr, s_data, s_wren};
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL rand_cyc%0d: got %06h required %06h", cyc, act, exp);
        end
    endtask

    task automatic rand_inputs();
        start       = ($urandom_range(0, 49) != 0);
        init_finish = ($urandom_range(0, 29) == 0);
        ksa_finish  = ($urandom_range(0, 29) == 0);
        prga_finish = ($urandom_range(0, 29) == 0);
        init_addr = 8'($urandom); ksa_addr = 8'($urandom); prga_addr = 8'($urandom);
        init_data = 8'($urandom); ksa_data = 8'($urandom); prga_data = 8'($urandom);
        init_wren = 1'($urandom); ksa_wren = 1'($urandom); prga_wren = 1'($urandom);
    endtask

    initial begin
        int bad;
        int exp_ph;

        //                ph  ia     id     ka     kd     pa     pd     iw kw pw ea     ed     ew
        vecs[0] = '{2, 8'h55, 8'h11, 8'h12, 8'h34, 8'h99, 8'h77, 1, 0, 1, 8'h12, 8'h34, 0};
        vecs[1] = '{1, 8'hA0, 8'h3C, 8'h01, 8'h02, 8'h03, 8'h04, 1, 1, 1, 8'hA0, 8'h3C, 1};
        vecs[2] = '{3, 8'h10, 8'h20, 8'h30, 8'h40, 8'hFF, 8'h81, 0, 0, 1, 8'hFF, 8'h81, 1};
        vecs[3] = '{3, 8'h10, 8'h20, 8'h30, 8'h40, 8'h5A, 8'hA5, 1, 1, 0, 8'h5A, 8'hA5, 0};
        vecs[4] = '{0, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 1, 1, 1, 8'h00, 8'h00, 0};
        vecs[5] = '{4, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 1, 1, 1, 8'h00, 8'h00, 0};
        vecs[6] = '{2, 8'hEE, 8'hDD, 8'h00, 8'hFF, 8'hCC, 8'hBB, 1, 1, 1, 8'h00, 8'hFF, 1};
        vecs[7] = '{1, 8'h7F, 8'h00, 8'h80, 8'h01, 8'h81, 8'h02, 0, 1, 1, 8'h7F, 8'h00, 0};

        // Reset state, including start high while reset is held.
        rst = 0; start = 1;
        clear_engines();
        init_wren = 1; init_addr = 8'h33; init_data = 8'h44;
        repeat (2) tick();
        chk("reset_outputs",
            {phase, done, err, init_start, ksa_start, prga_start, s_addr, s_data, s_wren}, 0);
        rst = 1;
        #1;
        chk("reset_release_idle", phase, 0);
        tick();
        chk("first_edge_init", phase, 1);

        // Mux table.
        for (int i = 0; i < 8; i++) begin
            goto(vecs[i].ph);
            init_addr = vecs[i].ia; init_data = vecs[i].id; init_wren = vecs[i].iw;
            ksa_addr  = vecs[i].ka; ksa_data  = vecs[i].kd; ksa_wren  = vecs[i].kw;
            prga_addr = vecs[i].pa; prga_data = vecs[i].pd; prga_wren = vecs[i].pw;
            #1;
            chk($sformatf("mux_vec%0d", i), {s_addr, s_data, s_wren},
                {vecs[i].ea, vecs[i].ed, vecs[i].ew});
        end

        // Full schedule: finishes after 256/768/300 cycles of each phase.
        goto(0);
        start = 1;
        bad = 0;
        for (int c = 1; c <= 1330; c++) begin
            tick();
            init_finish = (c == 257);
            ksa_finish  = (c == 1026);
            prga_finish = (c == 1327);
            exp_ph = (c <= 257) ? 1 : (c <= 1026) ? 2 : (c <= 1327) ? 3 : 0;
            if (phase !== 2'(exp_ph) || done !== (c >= 1328) || err !== 1'b0 ||
                init_start !== (exp_ph == 1) || ksa_start !== (exp_ph == 2) ||
                prga_start !== (exp_ph == 3))
                bad++;
            if (c == 1327) chk("sched_not_done_yet", done, 0);
            if (c == 1328) chk("sched_done_at_1327", done, 1);
        end
        chk("sched_cycle_errors", bad, 0);

        // KSA timeout.
        goto(2);
        ksa_wren = 1; ksa_addr = 8'h42;
        for (int k = 2; k <= TO + 1; k++) begin
            tick();
            if (k == TO) chk("timeout_still_ksa", {phase, err}, {2'd2, 1'b0});
        end
        chk("timeout_err", err, 1);
        chk("timeout_ksa_start", ksa_start, 0);
        chk("timeout_wren", {s_wren, s_addr}, 0);
        tick();
        chk("timeout_err_holds", err, 1);
        start = 0;
        tick();
        chk("timeout_to_idle", {phase, err, done}, 0);

        // Finish on the expiry cycle wins.
        goto(2);
        for (int k = 2; k <= TO; k++) tick();
        ksa_finish = 1;
        tick();
        ksa_finish = 0;
        chk("tie_to_prga", phase, 3);
        chk("tie_no_err", err, 0);

        // Async reset mid-PRGA.
        goto(3);
        prga_wren = 1; prga_addr = 8'hAB; prga_data = 8'hCD;
        #1;
        chk("prga_mux_live", {s_addr, s_data, s_wren}, {8'hAB, 8'hCD, 1'b1});
        rst = 0;
        #1;
        chk("async_reset_outputs",
            {phase, done, err, init_start, ksa_start, prga_start, s_addr, s_data, s_wren}, 0);
        rst = 1;
        tick();
        chk("reset_reenter_init", {phase, init_start}, {2'd1, 1'b1});

        // Abort during INIT.
        goto(1);
        start = 0;
        tick();
        chk("abort_idle", {phase, init_start, done, err}, 0);

        // Randomized run against the model.
        goto(0);
        ms = 0; mcnt = 0;
        rand_inputs();
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            model_step();
            #1;
            rand_inputs();
            #2;
            check_model(c);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
